// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART serial receiver.
//
// Samples the asynchronous serial line on the system clock, recovers framed
// bytes (1 start, 8 data LSB first, 1 stop) and reports each good byte with a
// one-cycle valid strobe, or a one-cycle framing-error strobe when the stop
// bit is low.
//
// Parameters:
//   clock_rate  system clock frequency in Hz
//   baud_rate   line rate in bits/s; clock_rate / baud_rate must be an even
//               integer of at least 4
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   ser_rx        in   asynchronous serial line, idle high
//   rx_data       out  last good byte
//   rx_valid      out  one-cycle pulse, rx_data updated on the same edge
//   rx_frame_err  out  one-cycle pulse when the stop bit is sampled low
//   rx_busy       out  high whenever the receiver is not idle
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every start/data/stop sample is the
//                        2-of-3 majority of the synchronized line over the
//                        last three cycles of the bit; latency is unchanged.
module uart_rx #(
  parameter int unsigned clock_rate = 8000000,
  parameter int unsigned baud_rate  = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned clocks_per_bit = clock_rate / baud_rate;
  localparam int unsigned DW             = $clog2(clocks_per_bit);

  // Half-bit load lands the start sample at the bit center; full-bit load
  // steps from center to center afterwards.
  localparam logic [DW-1:0] HALF_LOAD = DW'(clocks_per_bit / 2 - 1);
  localparam logic [DW-1:0] FULL_LOAD = DW'(clocks_per_bit - 1);
  localparam logic [DW-1:0] DLY_ONE   = DW'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  if ((clocks_per_bit < 4) || ((clocks_per_bit % 2) != 0) ||
      ((clocks_per_bit * baud_rate) != clock_rate)) begin : g_bad_rate
    $error("uart_rx: clock_rate/baud_rate must be an even integer >= 4");
  end

  logic [1:0]    sync_q, sync_d;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_frame_err_q, rx_frame_err_d;

  logic rx_s;
  logic sample;

  // Two-flop synchronizer; only the second stage feeds any decision.
  assign sync_d = {sync_q[0], ser_rx};
  assign rx_s   = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rx_s from the previous two cycles, i.e. at delay 2 and 1
  // when the decision is taken at delay 0.
  logic [1:0] hist_q, hist_d;

  assign hist_d = {hist_q[0], rx_s};
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) |
                  (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    delay_d        = delay_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          delay_d = HALF_LOAD;
        end
      end

      S_START: begin
        if (delay_q != '0) begin
          delay_d = delay_q - DLY_ONE;
        end else if (sample) begin
          // Line went back high before the start-bit center: noise.
          state_d = S_IDLE;
        end else begin
          state_d   = S_DATA;
          delay_d   = FULL_LOAD;
          bit_cnt_d = 3'd0;
        end
      end

      S_DATA: begin
        if (delay_q != '0) begin
          delay_d = delay_q - DLY_ONE;
        end else begin
          shift_d   = {sample, shift_q[7:1]};
          delay_d   = FULL_LOAD;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (delay_q != '0) begin
          delay_d = delay_q - DLY_ONE;
        end else if (sample) begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          rx_frame_err_d = 1'b1;
          state_d        = S_WAIT_HIGH;
        end
      end

      S_WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      sync_q         <= 2'b11;
      state_q        <= S_IDLE;
      delay_q        <= '0;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q         <= 2'b11;
`endif
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      delay_q        <= delay_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q         <= hist_d;
`endif
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx at 8 clocks per bit.
//
// Frames are driven onto ser_rx cycle by cycle. Every frame whose pulse is
// expected pushes a record (kind, data, edge number) into a queue; a monitor
// on the falling clock edge pops it when a pulse appears and compares kind,
// timing, data and busy. Any pulse with nothing queued is an error, and the
// queue must be empty at the end.
module tb_uart_rx;

  localparam int CPB = 8;
  // Edge offset from the first low sample of the start bit to the pulse.
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(
    .clock_rate(8000000),
    .baud_rate (1000000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ser_rx      (ser_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clock = ~clock;

  // Index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         at_edge;
  } ev_t;

  ev_t exp_q[$];
  int  last_valid_edge = -1;
  int  prev_valid_edge = -1;

  task automatic expect_pulse(input int k, input logic is_err, input logic [7:0] data);
    ev_t e;
    e.is_err  = is_err;
    e.data    = data;
    e.at_edge = k + LAT;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (rx_valid && rx_frame_err) begin
      check("pulse_overlap", 32'(rx_valid & rx_frame_err), 32'd0);
    end else if (rx_valid || rx_frame_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(rx_valid | rx_frame_err), 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_kind_err", 32'(rx_frame_err), 32'(e.is_err));
        check("pulse_edge", cyc, e.at_edge);
        check("pulse_data", 32'(rx_data), 32'(e.data));
        check("busy_at_pulse", 32'(rx_busy), 32'(e.is_err));
      end
      if (rx_valid) begin
        prev_valid_edge = last_valid_edge;
        last_valid_edge = cyc;
      end
    end
  end

  // Drive a level for n rising edges; returns 1 time unit after the last one.
  task automatic send_level(input logic v, input int n);
    ser_rx = v;
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  // glitch >= 0 inverts that data bit for the single cycle sampled at its center.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch);
    send_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        send_level(d[i], CPB / 2);
        send_level(!d[i], 1);
        send_level(d[i], CPB / 2 - 1);
      end else begin
        send_level(d[i], CPB);
      end
    end
    send_level(stop, CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         glitch;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  initial begin
    vec_t       vecs[8];
    logic [7:0] last_good;
    int         k;
    int         busy_cnt;
    logic       prev_err;

    vecs[0] = '{8'h55, 1'b1, -1, 10, 8'h55,     1'b0};
    vecs[1] = '{8'hA5, 1'b1, -1,  6, 8'hA5,     1'b0};
    vecs[2] = '{8'h3C, 1'b1, -1,  0, 8'h3C,     1'b0};
    vecs[3] = '{8'hFF, 1'b0, -1,  4, 8'h3C,     1'b1};
    vecs[4] = '{8'h12, 1'b1, -1,  3, 8'h12,     1'b0};
    vecs[5] = '{8'h00, 1'b1,  3,  5, GLITCH_EXP, 1'b0};
    vecs[6] = '{8'h80, 1'b1, -1,  0, 8'h80,     1'b0};
    vecs[7] = '{8'h01, 1'b0, -1,  2, 8'h80,     1'b1};

    reset  = 1'b1;
    ser_rx = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_frame_err", 32'(rx_frame_err), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;

    // Table-driven frames, including back-to-back and the glitch case.
    for (int i = 0; i < 8; i++) begin
      send_level(1'b1, vecs[i].gap);
      k = cyc + 1;
      expect_pulse(k, vecs[i].exp_err, vecs[i].exp_data);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch);
      check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      if (i == 2) begin
        check("b2b_spacing", last_valid_edge - prev_valid_edge, 10 * CPB);
      end
    end
    last_good = 8'h80;

    // Bad stop, then a 30-cycle break: no restart until the line is high.
    send_level(1'b1, 6);
    k = cyc + 1;
    expect_pulse(k, 1'b1, last_good);
    send_frame(8'hFF, 1'b0, -1);
    send_level(1'b0, 30);
    check("break_busy", 32'(rx_busy), 32'd1);
    check("break_rx_data", 32'(rx_data), 32'(last_good));
    send_level(1'b1, 4);
    check("break_released_busy", 32'(rx_busy), 32'd0);
    k = cyc + 1;
    expect_pulse(k, 1'b0, 8'h12);
    send_frame(8'h12, 1'b1, -1);
    last_good = 8'h12;
    check("after_break_rx_data", 32'(rx_data), 32'h12);

    // False start: low for 2 edges only.
    send_level(1'b1, 5);
    ser_rx   = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      busy_cnt += int'(rx_busy);
      @(posedge clock);
      #1;
      if (i == 1) ser_rx = 1'b1;
    end
    check("false_start_busy_cycles", busy_cnt, 4);
    check("false_start_rx_data", 32'(rx_data), 32'(last_good));

    // Reset in the middle of data bit 4 of 0x81, held until the frame ends.
    send_level(1'b1, 5);
    send_level(1'b0, CPB);
    send_level(1'b1, CPB);
    send_level(1'b0, 3 * CPB);
    send_level(1'b0, CPB / 2);
    reset = 1'b1;
    send_level(1'b0, CPB / 2);
    send_level(1'b0, 2 * CPB);
    send_level(1'b1, 2 * CPB);
    reset = 1'b0;
    send_level(1'b1, 4);
    last_good = 8'h00;
    check("mid_frame_reset_rx_data", 32'(rx_data), 32'h00);
    check("mid_frame_reset_busy", 32'(rx_busy), 32'd0);
    k = cyc + 1;
    expect_pulse(k, 1'b0, 8'h81);
    send_frame(8'h81, 1'b1, -1);
    last_good = 8'h81;
    check("after_reset_rx_data", 32'(rx_data), 32'h81);

    // Random frames against the frame-level model.
    prev_err = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       stop;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gap  = prev_err ? int'($urandom_range(2, 12)) : int'($urandom_range(0, 12));
      send_level(1'b1, gap);
      k = cyc + 1;
      if (stop) last_good = d;
      expect_pulse(k, !stop, last_good);
      send_frame(d, stop, -1);
      check("rand_rx_data", 32'(rx_data), 32'(last_good));
      prev_err = !stop;
    end
    send_level(1'b1, 6);

    check("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
